// File: rtl/vga_pkg.sv
// Shared fade-controller encodings: FSM states and one-hot display levels.
package vga_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DARK  = 2'd1,
        MID   = 2'd2,
        LIGHT = 2'd3
    } fade_state_t;

    localparam logic [2:0] LVL_OFF   = 3'b000;
    localparam logic [2:0] LVL_DARK  = 3'b100;
    localparam logic [2:0] LVL_MID   = 3'b010;
    localparam logic [2:0] LVL_LIGHT = 3'b001;

    // Display level driven while the FSM sits in a given state.
    function automatic logic [2:0] level_of(input fade_state_t s);
        logic [2:0] lvl;
        case (s)
            DARK:    lvl = LVL_DARK;
            MID:     lvl = LVL_MID;
            LIGHT:   lvl = LVL_LIGHT;
            default: lvl = LVL_OFF;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton front end: 2-flop synchronizer, stability debounce and a
// one-cycle pulse on each debounced press (1->0 of the active-low key).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic iVGA_CLK,
    input  logic iRST_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_s1;
    logic          key_s2;
    logic          key_db;
    logic [CW-1:0] cnt;

    // Bring the raw key into the pixel clock domain; idle level is released.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
        end
    end

    // Accept a new key level only after it has differed for the full window;
    // any return to the debounced level restarts the count.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_db <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else if (key_s2 == key_db) begin
            cnt   <= '0;
            press <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            key_db <= key_s2;
            press  <= ~key_s2;
        end else begin
            cnt   <= cnt + CW'(1);
            press <= 1'b0;
        end
    end

endmodule

// File: rtl/arrow_fade_ctrl.sv
// Arrow fade sequencer: each accepted key press starts a dark->mid->light
// fade, stepping only on frame boundaries so the level never changes mid-frame.
//
//   state | meaning
//   OFF   | arrow hidden, waiting for a press
//   DARK  | first intensity step after a press (or retrigger)
//   MID   | second intensity step
//   LIGHT | last intensity step before returning to OFF
module arrow_fade_ctrl
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int FRAMES_PER_LEVEL = 8
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iKEY_n,
    input  logic       iVS,
    output logic [2:0] oLevel,
    output logic       oPress,
    output logic       oBusy
);

    localparam int FW = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAMES_PER_LEVEL - 1);

    logic          press;
    logic          vs_s1;
    logic          vs_s2;
    logic          vs_hist;
    logic [2:0]    vs_vld;
    logic          frame_tick;
    logic          pending_q;
    fade_state_t   state_q;
    fade_state_t   state_d;
    logic [FW-1:0] frm_cnt_q;
    logic [FW-1:0] frm_cnt_d;
    logic [2:0]    level_q;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .iVGA_CLK(iVGA_CLK),
        .iRST_n  (iRST_n),
        .key_n   (iKEY_n),
        .press   (press)
    );

    // Synchronize vsync and keep one stage of history for edge detection.
    // vs_vld marks when the history holds a real sample, so a vsync already
    // low when reset is released is not mistaken for a falling edge.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_hist <= 1'b1;
            vs_vld  <= '0;
        end else begin
            vs_s1   <= iVS;
            vs_s2   <= vs_s1;
            vs_hist <= vs_s2;
            vs_vld  <= {vs_vld[1:0], 1'b1};
        end
    end

    assign frame_tick = vs_vld[2] & vs_hist & ~vs_s2;

    // A press waits here until the next frame boundary consumes it.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pending_q <= 1'b0;
        end else if (frame_tick) begin
            pending_q <= 1'b0;
        end else if (press) begin
            pending_q <= 1'b1;
        end
    end

    // State, frame counter and registered level all move on the tick edge.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= OFF;
            frm_cnt_q <= '0;
            level_q   <= LVL_OFF;
        end else begin
            state_q   <= state_d;
            frm_cnt_q <= frm_cnt_d;
            level_q   <= level_of(state_d);
        end
    end

    // Next-state: a press seen at the tick (pending or arriving that very
    // cycle) restarts at DARK; otherwise step through levels every N frames.
    always_comb begin
        state_d   = state_q;
        frm_cnt_d = frm_cnt_q;
        if (frame_tick) begin
            if (pending_q || press) begin
                state_d   = DARK;
                frm_cnt_d = '0;
            end else if (state_q != OFF) begin
                if (frm_cnt_q == FRM_LAST) begin
                    frm_cnt_d = '0;
                    case (state_q)
                        DARK:    state_d = MID;
                        MID:     state_d = LIGHT;
                        default: state_d = OFF;
                    endcase
                end else begin
                    frm_cnt_d = frm_cnt_q + FW'(1);
                end
            end
        end
    end

    assign oLevel = level_q;
    assign oPress = press;
    assign oBusy  = (level_q != LVL_OFF) | pending_q;

endmodule

// File: tb/tb_arrow_fade_ctrl.sv
// Scoreboard bench for arrow_fade_ctrl with DEBOUNCE_CYCLES=4, FRAMES_PER_LEVEL=2.
module tb_arrow_fade_ctrl;

    localparam int DC  = 4;
    localparam int FPL = 2;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       iKEY_n   = 1'b1;
    logic       iVS      = 1'b1;
    logic [2:0] oLevel;
    logic       oPress;
    logic       oBusy;

    arrow_fade_ctrl #(
        .DEBOUNCE_CYCLES (DC),
        .FRAMES_PER_LEVEL(FPL)
    ) dut (
        .iVGA_CLK(iVGA_CLK),
        .iRST_n  (iRST_n),
        .iKEY_n  (iKEY_n),
        .iVS     (iVS),
        .oLevel  (oLevel),
        .oPress  (oPress),
        .oBusy   (oBusy)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    int cyc = 0;
    always @(posedge iVGA_CLK) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] lvl;
        int         due;
    } exp_t;

    exp_t       lvl_q[$];
    int         press_exp_q[$];
    int         press_model_q[$];
    logic [2:0] sched[$];

    int         n_vec = 0;
    int         n_bad = 0;
    bit         final_req = 0;
    bit         final_done = 0;

    // Reference model: a tick consumes every press that has landed by then;
    // a press restarts a fixed schedule of levels, one entry per frame.
    task automatic model_tick(input int t);
        exp_t       e;
        bit         pend;
        logic [2:0] lvl;
        pend = 0;
        while (press_model_q.size() > 0 && press_model_q[0] <= t) begin
            void'(press_model_q.pop_front());
            pend = 1;
        end
        if (pend) begin
            sched.delete();
            for (int i = 0; i < FPL; i++) sched.push_back(3'b100);
            for (int i = 0; i < FPL; i++) sched.push_back(3'b010);
            for (int i = 0; i < FPL; i++) sched.push_back(3'b001);
        end
        lvl   = (sched.size() > 0) ? sched.pop_front() : 3'b000;
        e.lvl = lvl;
        e.due = t + 1;
        lvl_q.push_back(e);
    endtask

    task automatic note_press(input int p);
        press_model_q.push_back(p);
        press_exp_q.push_back(p);
    endtask

    // All stimulus tasks start and end on a falling clock edge.
    task automatic tick_vs();
        iVS = 1'b0;
        model_tick(cyc + 2);
        repeat (3) @(negedge iVGA_CLK);
        iVS = 1'b1;
        repeat (3) @(negedge iVGA_CLK);
    endtask

    task automatic key_press(input int bounce, input int hold);
        if (bounce > 0) begin
            iKEY_n = 1'b0;
            repeat (bounce) @(negedge iVGA_CLK);
            iKEY_n = 1'b1;
            @(negedge iVGA_CLK);
        end
        iKEY_n = 1'b0;
        note_press(cyc + 2 + DC);
        repeat (hold) @(negedge iVGA_CLK);
        iKEY_n = 1'b1;
        repeat (DC + 4) @(negedge iVGA_CLK);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each falling clock edge or reset assertion.
    exp_t       mon_e;
    logic [2:0] cur_exp = 3'b000;
    bit         m_pend = 0;
    bit         prev_exp_press = 0;
    bit         tick_now;
    bit         exp_press;

    always begin
        @(negedge iVGA_CLK or negedge iRST_n);
        #1;
        if (!iRST_n) begin
            check("rst_level", oLevel, 3'b000);
            check("rst_press", oPress, 1'b0);
            check("rst_busy", oBusy, 1'b0);
            cur_exp        = 3'b000;
            m_pend         = 0;
            prev_exp_press = 0;
        end else begin
            if (lvl_q.size() > 0 && lvl_q[0].due == cyc) begin
                mon_e    = lvl_q.pop_front();
                cur_exp  = mon_e.lvl;
                m_pend   = 0;
                tick_now = 1;
                check("level_at_tick", oLevel, cur_exp);
            end else begin
                tick_now = 0;
                check("level_hold", oLevel, cur_exp);
            end
            if (prev_exp_press && !tick_now) m_pend = 1;
            exp_press = (press_exp_q.size() > 0 && press_exp_q[0] == cyc);
            if (exp_press) void'(press_exp_q.pop_front());
            check("press_pulse", oPress, exp_press);
            check("busy", oBusy, (cur_exp != 3'b000) || m_pend);
            prev_exp_press = exp_press;
            if (final_req && !final_done) begin
                check("queues_drained", lvl_q.size() + press_exp_q.size(), 0);
                final_done = 1;
            end
        end
    end

    int op;
    int b;
    int h;
    int off;

    initial begin
        repeat (3) @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        repeat (5) @(negedge iVGA_CLK);

        // Bouncy press followed by a full fade.
        key_press(3, 10);
        repeat (7) tick_vs();

        // Retrigger while at the lightest level.
        key_press(0, 6);
        repeat (5) tick_vs();
        key_press(0, 6);
        repeat (8) tick_vs();

        // Key held across several frames, then released and pressed again.
        fork
            key_press(0, 40);
            begin
                repeat (DC + 4) @(negedge iVGA_CLK);
                repeat (7) tick_vs();
            end
        join
        key_press(0, 6);
        repeat (7) tick_vs();

        // Press lands in the same cycle as the frame tick.
        fork
            key_press(0, 8);
            begin
                repeat (DC) @(negedge iVGA_CLK);
                tick_vs();
            end
        join
        repeat (7) tick_vs();

        // Reset mid-fade, released while vsync is already low.
        key_press(0, 6);
        repeat (3) tick_vs();
        #2;
        iRST_n = 1'b0;
        lvl_q.delete();
        press_exp_q.delete();
        press_model_q.delete();
        sched.delete();
        iVS = 1'b0;
        repeat (3) @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        repeat (8) @(negedge iVGA_CLK);
        iVS = 1'b1;
        repeat (4) @(negedge iVGA_CLK);
        key_press(0, 6);
        repeat (2) tick_vs();

        // Randomized interleaving of frames, presses and idle time.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            b  = $urandom_range(0, DC - 1);
            h  = $urandom_range(DC + 1, 20);
            case (op)
                0: tick_vs();
                1: key_press(b, h);
                2: repeat ($urandom_range(1, 10)) @(negedge iVGA_CLK);
                default: begin
                    off = $urandom_range(0, 12);
                    fork
                        key_press(b, h);
                        begin
                            repeat (off) @(negedge iVGA_CLK);
                            tick_vs();
                        end
                    join
                end
            endcase
        end

        repeat (20) @(negedge iVGA_CLK);
        final_req = 1;
        repeat (3) @(negedge iVGA_CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/arrow_fade_ctrl.md
ARROW_FADE_CTRL -- requirements
Module: arrow_fade_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable cycles (10 ms at 25 MHz) before a key change is accepted; legal range >= 1.
REQ-002 SHALL have parameter FRAMES_PER_LEVEL, default 8, meaning frames spent at each non-off intensity level; legal range >= 1.
REQ-003 SHALL have port iVGA_CLK, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-004 SHALL have port iRST_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port iKEY_n, input, 1 bit: raw asynchronous pushbutton, low = pressed.
REQ-006 SHALL have port iVS, input, 1 bit: vertical sync from the sync generator, active low.
REQ-007 SHALL have port oLevel, output, 3 bits: one-hot intensity level for the display stage (100 dark, 010 mid, 001 light, 000 off).
REQ-008 SHALL have port oPress, output, 1 bit: one-cycle pulse per accepted press.
REQ-009 SHALL have port oBusy, output, 1 bit: high whenever oLevel != 000 or a press is pending.

Function
REQ-010 SHALL pass iKEY_n and iVS through 2-flop synchronizers before any use.
REQ-011 Debounce: SHALL update the debounced key only after the synchronized key differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch SHALL restart the count; counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).
REQ-012 SHALL pulse oPress for exactly one cycle on a debounced 1->0 transition; a held key SHALL give one pulse only; the key must be debounced-released before another press is accepted.
REQ-013 SHALL generate an internal one-cycle frame_tick on each synchronized iVS 1->0 edge.
REQ-014 An accepted press SHALL set a pending flag; the flag SHALL be cleared only by a frame_tick.
REQ-015 FSM states SHALL be OFF, DARK, MID, LIGHT, with oLevel 000, 100, 010, 001 respectively.
REQ-016 On frame_tick with pending set, from any state: SHALL go to DARK, clear frame counter, clear pending (retrigger).
REQ-017 On frame_tick without pending in DARK/MID/LIGHT: SHALL increment frame counter; at FRAMES_PER_LEVEL-1 SHALL clear it and advance DARK->MID->LIGHT->OFF.
REQ-018 OFF with no pending SHALL hold; frame counter width SHALL be max(1, $clog2(FRAMES_PER_LEVEL)).
REQ-019 oLevel SHALL be registered and SHALL change only on the edge consuming frame_tick, i.e. exactly 3 iVGA_CLK edges after the first edge that samples iVS low (counting that edge), so it never changes mid-frame.
REQ-020 Press accepted in the same cycle as frame_tick SHALL be treated as pending at that tick (DARK entered at that tick).
REQ-021 oLevel SHALL always be one-hot or 000.

Reset
REQ-022 Asserting iRST_n low SHALL immediately force: oLevel=000, oPress=0, oBusy=0, FSM=OFF, pending=0, both counters=0, key synchronizers and debounced key=1, iVS synchronizers and edge history=1.
REQ-023 Reset mid-fade SHALL discard pending press and state; no frame_tick SHALL be produced by the first iVS sample after release if iVS is already low.

Structure
REQ-024 SHALL place state encoding (OFF/DARK/MID/LIGHT) and level constants LVL_OFF/LVL_DARK/LVL_MID/LVL_LIGHT in shared package vga_pkg.
REQ-025 SHALL instantiate one sub-module key_debounce (synchronizer, debounce counter, press edge pulse); frame_tick and FSM SHALL live in the top.

Verification (DEBOUNCE_CYCLES=4, FRAMES_PER_LEVEL=2)
REQ-026 Reset: hold iRST_n low mid-operation -> oLevel=000, oPress=0, oBusy=0 in the same cycle; no tick on release with iVS low.
REQ-027 Bounce: iKEY_n low 3 cycles, high 1, low 10 -> exactly one oPress pulse, oBusy high.
REQ-028 Fade: press, then 7 iVS falling edges -> oLevel 100,100,010,010,001,001,000, each change exactly 3 edges after iVS sampled low.
REQ-029 Retrigger: press while oLevel=001 -> next frame_tick gives oLevel=100, counter restarts (two frames at 100).
REQ-030 Held key: iKEY_n low for 5 frames -> one oPress, one fade sequence; release then press -> second oPress.
REQ-031 Coincidence: debounced press lands same cycle as frame_tick -> oLevel=100 at that tick, pending clear afterwards.
